if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/lc3b_types.sv | 22 ++
 rtl/if_stage_if.sv | 29 ++
 rtl/if_predecode.sv | 23 ++
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b fetch types.
//   lc3b_word    : 16-bit machine word / byte address
//   lc3b_reg     : 3-bit register specifier
//   lc3b_ipacket : fetched instruction with its pc and predecoded register fields
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word ir;
        lc3b_reg  sr1;
        lc3b_reg  sr2;
        lc3b_reg  dr_sr;
        logic     sr2_mux_sel;
    } lc3b_ipacket;

    // Instructions are one word, byte addressed.
    localparam lc3b_word INSTR_BYTES = 16'd2;

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory request/response bus.
//   imem_read    : request strobe (held until imem_resp)
//   imem_address : request address (stable while the request is open)
//   imem_rdata   : returned instruction word
//   imem_resp    : one-cycle response strobe
// master = fetch unit, slave = instruction memory.
interface if_stage_if;
    import lc3b_types::*;

    logic     imem_read;
    lc3b_word imem_address;
    lc3b_word imem_rdata;
    logic     imem_resp;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_rdata,
        output imem_resp
    );

endinterface

// File: rtl/if_predecode.sv
// Combinational predecode of one fetched word into an instruction packet.
//   pc     : address the word was fetched from
//   ir     : fetched instruction word
//   packet : pc, ir and the register fields extracted from ir
module if_predecode
    import lc3b_types::*;
(
    input  lc3b_word    pc,
    input  lc3b_word    ir,
    output lc3b_ipacket packet
);

    always_comb begin
        packet             = '0;
        packet.pc          = pc;
        packet.ir          = ir;
        packet.dr_sr       = ir[11:9];
        packet.sr1         = ir[8:6];
        packet.sr2         = ir[2:0];
        packet.sr2_mux_sel = ir[5];
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with a one-entry skid buffer.
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall         : IF/ID register holding; current packet not consumed
//   redirect      : control-flow change, new address on redirect_pc
//   imem          : instruction memory bus (master side)
//   ipacket_out   : predecoded instruction packet
//   ipacket_valid : ipacket_out holds a real instruction
// FETCH keeps a request open at pc. A response that arrives while the output
// packet is stalled is parked in the skid register (HOLD). A redirect while a
// request is still open moves to SQUASH, which keeps the old request alive
// until its response arrives and then drops the data.
module if_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  lc3b_word    redirect_pc,
    if_stage_if.master  imem,
    output lc3b_ipacket ipacket_out,
    output logic        ipacket_valid
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        SQUASH
    } state_e;

    state_e      state_q,   state_d;
    lc3b_word    pc_q,      pc_d;
    lc3b_word    sq_addr_q, sq_addr_d;
    lc3b_ipacket packet_q,  packet_d;
    lc3b_ipacket skid_q,    skid_d;
    logic        valid_q,   valid_d;
    lc3b_ipacket fetched;

    if_predecode u_predecode (
        .pc     (pc_q),
        .ir     (imem.imem_rdata),
        .packet (fetched)
    );

    // Gated by rst_n so the request drops immediately while reset is held,
    // yet is already asserted in the first FETCH cycle after release.
    assign imem.imem_read    = rst_n && (state_q != HOLD);
    // SQUASH keeps presenting the abandoned address; pc already holds the
    // redirect target.
    assign imem.imem_address = (state_q == SQUASH) ? sq_addr_q : pc_q;

    assign ipacket_out   = packet_q;
    assign ipacket_valid = valid_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sq_addr_d = sq_addr_q;
        packet_d  = packet_q;
        skid_d    = skid_q;
        valid_d   = valid_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    skid_d  = '0;
                    if (!imem.imem_resp) begin
                        // Request still open: let it finish, then drop it.
                        state_d   = SQUASH;
                        sq_addr_d = pc_q;
                    end
                end else if (imem.imem_resp) begin
                    pc_d = pc_q + INSTR_BYTES;
                    if (!valid_q || !stall) begin
                        packet_d = fetched;
                        valid_d  = 1'b1;
                    end else begin
                        skid_d  = fetched;
                        state_d = HOLD;
                    end
                end else if (valid_q && !stall) begin
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    skid_d  = '0;
                    state_d = FETCH;
                end else if (!stall) begin
                    packet_d = skid_q;
                    skid_d   = '0;
                    state_d  = FETCH;
                end
            end

            SQUASH: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    skid_d  = '0;
                end
                if (imem.imem_resp) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            sq_addr_q <= RESET_PC;
            packet_q  <= '0;
            skid_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sq_addr_q <= sq_addr_d;
            packet_q  <= packet_d;
            skid_q    <= skid_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    lc3b_word    redirect_pc = '0;
    lc3b_ipacket ipacket_out;
    logic        ipacket_valid;

    if_stage_if imem_bus ();

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem          (imem_bus),
        .ipacket_out   (ipacket_out),
        .ipacket_valid (ipacket_valid)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // Instruction memory model
    lc3b_word    mem [0:65535];
    logic        pending = 1'b0;
    lc3b_word    req_addr = '0;
    int unsigned wait_cnt = 0;
    int unsigned fixed_lat = 0;
    logic        rand_lat = 1'b0;

    // One clock cycle: at the falling edge the memory answers the open request
    // and the new stall/redirect inputs are applied; returns 1ns later so the
    // caller observes the cycle's registered outputs.
    task automatic step(input logic st, input logic rd, input lc3b_word rpc);
        @(negedge clk);
        if (imem_bus.imem_read) begin
            if (!pending) begin
                pending  = 1'b1;
                req_addr = imem_bus.imem_address;
                wait_cnt = rand_lat ? $urandom_range(0, 2) : fixed_lat;
            end else begin
                checks++;
                if (imem_bus.imem_address !== req_addr) begin
                    errors++;
                    $display("FAIL addr_stable: imem_address=%h required %h", imem_bus.imem_address, req_addr);
                end
            end
            if (wait_cnt == 0) begin
                imem_bus.imem_resp  = 1'b1;
                imem_bus.imem_rdata = mem[imem_bus.imem_address];
                pending = 1'b0;
            end else begin
                imem_bus.imem_resp  = 1'b0;
                imem_bus.imem_rdata = lc3b_word'($urandom);
                wait_cnt--;
            end
        end else begin
            imem_bus.imem_resp  = 1'b0;
            imem_bus.imem_rdata = lc3b_word'($urandom);
        end
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_bus.imem_resp = 1'b0;
        imem_bus.imem_rdata = '0;
        pending = 1'b0;
        rand_lat = 1'b0;
        fixed_lat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ipacket_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", ipacket_valid); end
        checks++;
        if (imem_bus.imem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b required 0", imem_bus.imem_read); end
        checks++;
        if (ipacket_out !== '0) begin errors++; $display("FAIL reset_packet: got %h required 0", ipacket_out); end
        do_reset();
        #1;
        checks++;
        if (imem_bus.imem_read !== 1'b1 || imem_bus.imem_address !== 16'h0000) begin
            errors++;
            $display("FAIL reset_first_fetch: read=%b addr=%h required read=1 addr=0000", imem_bus.imem_read, imem_bus.imem_address);
        end
    endtask

    task automatic test_basic();
        do_reset();
        step(0, 0, '0);
        step(0, 0, '0);
        checks++;
        if (ipacket_valid !== 1'b1 || ipacket_out.pc !== 16'h0000 || ipacket_out.ir !== 16'h1283) begin
            errors++;
            $display("FAIL basic_packet: valid=%b pc=%h ir=%h required 1 0000 1283", ipacket_valid, ipacket_out.pc, ipacket_out.ir);
        end
        checks++;
        if (ipacket_out.dr_sr !== 3'd1 || ipacket_out.sr1 !== 3'd2 || ipacket_out.sr2 !== 3'd3 || ipacket_out.sr2_mux_sel !== 1'b0) begin
            errors++;
            $display("FAIL basic_predecode: dr=%0d sr1=%0d sr2=%0d mux=%b required 1 2 3 0",
                     ipacket_out.dr_sr, ipacket_out.sr1, ipacket_out.sr2, ipacket_out.sr2_mux_sel);
        end
        checks++;
        if (imem_bus.imem_address !== 16'h0002) begin errors++; $display("FAIL basic_next_addr: got %h required 0002", imem_bus.imem_address); end
        step(0, 0, '0);
        checks++;
        if (ipacket_valid !== 1'b1 || ipacket_out.pc !== 16'h0002 || ipacket_out.ir !== mem[2]) begin
            errors++;
            $display("FAIL basic_throughput: valid=%b pc=%h ir=%h required 1 0002 %h", ipacket_valid, ipacket_out.pc, ipacket_out.ir, mem[2]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, '0);
            if (i > 0) begin
                checks++;
                if (imem_bus.imem_read !== 1'b0 || ipacket_valid !== 1'b1 || ipacket_out.pc !== 16'h0000) begin
                    errors++;
                    $display("FAIL stall_hold: read=%b valid=%b pc=%h required 0 1 0000", imem_bus.imem_read, ipacket_valid, ipacket_out.pc);
                end
            end
        end
        step(0, 0, '0);
        checks++;
        if (ipacket_out.pc !== 16'h0000 || ipacket_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_cycle: pc=%h valid=%b required 0000 1", ipacket_out.pc, ipacket_valid);
        end
        step(0, 0, '0);
        checks++;
        if (ipacket_valid !== 1'b1 || ipacket_out.pc !== 16'h0002 || ipacket_out.ir !== mem[2]) begin
            errors++;
            $display("FAIL stall_skid_word: valid=%b pc=%h ir=%h required 1 0002 %h", ipacket_valid, ipacket_out.pc, ipacket_out.ir, mem[2]);
        end
        checks++;
        if (imem_bus.imem_read !== 1'b1 || imem_bus.imem_address !== 16'h0004) begin
            errors++;
            $display("FAIL stall_next_fetch: read=%b addr=%h required 1 0004", imem_bus.imem_read, imem_bus.imem_address);
        end
    endtask

    task automatic test_squash();
        logic got;
        do_reset();
        step(0, 1, 16'h0010);
        fixed_lat = 2;
        step(0, 0, '0);
        checks++;
        if (imem_bus.imem_address !== 16'h0010) begin errors++; $display("FAIL squash_setup_addr: got %h required 0010", imem_bus.imem_address); end
        step(0, 1, 16'h3000);
        step(0, 0, '0);
        checks++;
        if (imem_bus.imem_read !== 1'b1 || imem_bus.imem_address !== 16'h0010 || ipacket_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_old_req: read=%b addr=%h valid=%b required 1 0010 0", imem_bus.imem_read, imem_bus.imem_address, ipacket_valid);
        end
        step(0, 0, '0);
        checks++;
        if (imem_bus.imem_address !== 16'h3000 || ipacket_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_new_req: addr=%h valid=%b required 3000 0", imem_bus.imem_address, ipacket_valid);
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, 0, '0);
            if (ipacket_valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL squash_timeout: no packet within 10 cycles, required one");
        end else if (ipacket_out.pc !== 16'h3000 || ipacket_out.ir !== mem[16'h3000]) begin
            errors++;
            $display("FAIL squash_first_pkt: pc=%h ir=%h required 3000 %h", ipacket_out.pc, ipacket_out.ir, mem[16'h3000]);
        end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        step(0, 0, '0);
        step(0, 1, 16'h1234);
        step(0, 0, '0);
        checks++;
        if (ipacket_valid !== 1'b0 || imem_bus.imem_address !== 16'h1234) begin
            errors++;
            $display("FAIL redir_resp: valid=%b addr=%h required 0 1234", ipacket_valid, imem_bus.imem_address);
        end
        step(0, 0, '0);
        checks++;
        if (ipacket_valid !== 1'b1 || ipacket_out.pc !== 16'h1234) begin
            errors++;
            $display("FAIL redir_resp_pkt: valid=%b pc=%h required 1 1234", ipacket_valid, ipacket_out.pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 1, 16'hFFFE);
        step(0, 0, '0);
        checks++;
        if (imem_bus.imem_address !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr: got %h required fffe", imem_bus.imem_address); end
        step(0, 0, '0);
        checks++;
        if (ipacket_out.pc !== 16'hFFFE || imem_bus.imem_address !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_next: pc=%h addr=%h required fffe 0000", ipacket_out.pc, imem_bus.imem_address);
        end
    endtask

    task automatic test_reset_async();
        // Reset while in HOLD with a parked skid word.
        do_reset();
        step(0, 0, '0);
        step(1, 0, '0);
        step(1, 0, '0);
        checks++;
        if (imem_bus.imem_read !== 1'b0 || ipacket_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_hold_setup: read=%b valid=%b required 0 1", imem_bus.imem_read, ipacket_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ipacket_valid !== 1'b0 || ipacket_out !== '0 || imem_bus.imem_read !== 1'b0) begin
            errors++;
            $display("FAIL areset_hold: valid=%b pkt=%h read=%b required 0 0 0", ipacket_valid, ipacket_out, imem_bus.imem_read);
        end
        stall = 1'b0;
        pending = 1'b0;
        imem_bus.imem_resp = 1'b0;
        #1 rst_n = 1'b1;
        step(0, 0, '0);
        step(0, 0, '0);
        checks++;
        if (ipacket_valid !== 1'b1 || ipacket_out.pc !== 16'h0000 || ipacket_out.ir !== mem[0]) begin
            errors++;
            $display("FAIL areset_hold_restart: valid=%b pc=%h ir=%h required 1 0000 %h", ipacket_valid, ipacket_out.pc, ipacket_out.ir, mem[0]);
        end

        // Reset with a slow request outstanding at a non-reset address.
        do_reset();
        step(0, 1, 16'h0400);
        fixed_lat = 2;
        step(0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_bus.imem_read !== 1'b0 || ipacket_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_req: read=%b valid=%b required 0 0", imem_bus.imem_read, ipacket_valid);
        end
        pending = 1'b0;
        imem_bus.imem_resp = 1'b0;
        fixed_lat = 0;
        #1 rst_n = 1'b1;
        step(0, 0, '0);
        checks++;
        if (imem_bus.imem_address !== 16'h0000 || imem_bus.imem_read !== 1'b1) begin
            errors++;
            $display("FAIL areset_req_restart: addr=%h read=%b required 0000 1", imem_bus.imem_address, imem_bus.imem_read);
        end
    endtask

    // Random stall/redirect/latency against an in-order stream model: every
    // consumed packet must be the next sequential word after the last
    // redirect target (or reset address).
    task automatic test_random();
        lc3b_word exp_pc;
        lc3b_word exp_ir;
        logic st, rd;
        lc3b_word rpc;
        int delivered;
        do_reset();
        rand_lat = 1'b1;
        exp_pc = 16'h0000;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFC : (lc3b_word'($urandom) & 16'hFFFE);
            step(st, rd, rpc);
            if (ipacket_valid && !stall && !redirect) begin
                exp_ir = mem[exp_pc];
                checks++;
                if (ipacket_out.pc !== exp_pc || ipacket_out.ir !== exp_ir ||
                    ipacket_out.dr_sr !== lc3b_reg'(exp_ir >> 9) ||
                    ipacket_out.sr1 !== lc3b_reg'(exp_ir >> 6) ||
                    ipacket_out.sr2 !== lc3b_reg'(exp_ir) ||
                    ipacket_out.sr2_mux_sel !== exp_ir[5]) begin
                    errors++;
                    $display("FAIL random_stream: cycle %0d pkt=%h required pc=%h ir=%h", i, ipacket_out, exp_pc, exp_ir);
                end
                exp_pc = exp_pc + 16'd2;
                delivered++;
            end
            if (redirect) exp_pc = redirect_pc;
        end
        checks++;
        if (delivered < 300) begin
            errors++;
            $display("FAIL random_progress: delivered %0d packets required at least 300", delivered);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = lc3b_word'($urandom);
        mem[0] = 16'h1283;
        imem_bus.imem_resp = 1'b0;
        imem_bus.imem_rdata = '0;
        test_reset();
        test_basic();
        test_stall();
        test_squash();
        test_redirect_resp();
        test_wrap();
        test_reset_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
